// File: rtl/reorder_buffer_pkg.sv
// -----------------------------------------------------------------------------
// reorder_buffer_pkg
//   Shared definitions for the reorder buffer slice: the ROB address/depth
//   macros, the per-entry field widths, the exception-type bus (reused from
//   the core's exception header when that header is already in scope), and
//   the packed payload record stored in every ROB slot.
//   Optional feature macro used by this slice: ROB_OPERAND_READ_EN.
// -----------------------------------------------------------------------------
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif
`ifndef EXC_TYPE_NULL
`define EXC_TYPE_NULL 5'h00
`endif
`ifndef ROB_ADDR_WIDTH
`define ROB_ADDR_WIDTH 4
`endif
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS (`ROB_ADDR_WIDTH-1):0
`endif
`ifndef ROB_DEPTH
`define ROB_DEPTH (1 << `ROB_ADDR_WIDTH)
`endif
`ifndef ROB_REG_ADDR_BUS
`define ROB_REG_ADDR_BUS 4:0
`endif
`ifndef ROB_DATA_BUS
`define ROB_DATA_BUS 31:0
`endif
`ifndef ROB_PC_BUS
`define ROB_PC_BUS 31:0
`endif

package reorder_buffer_pkg;

    // Exception codes carried through the ROB; zero means "no exception".
    localparam logic [`EXC_TYPE_BUS] EXC_NONE = 5'h00;
    localparam logic [`EXC_TYPE_BUS] EXC_IF   = 5'h01;
    localparam logic [`EXC_TYPE_BUS] EXC_RI   = 5'h02;
    localparam logic [`EXC_TYPE_BUS] EXC_OV   = 5'h03;
    localparam logic [`EXC_TYPE_BUS] EXC_SYS  = 5'h04;

    // Payload of one ROB slot; valid/done live outside the record so that
    // flush can clear them without touching the payload.
    typedef struct packed {
        logic                      reg_write_en;
        logic [`ROB_REG_ADDR_BUS]  reg_addr;
        logic [`ROB_DATA_BUS]      data;
        logic [`EXC_TYPE_BUS]      exc_type;
        logic                      is_delayslot;
        logic [`ROB_PC_BUS]        pc;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// -----------------------------------------------------------------------------
// rob_ptr
//   Wrap-bit pointer counter used for the ROB head and tail. The pointer is
//   ADDR_WIDTH+1 bits wide: the low bits index the storage and the MSB toggles
//   every time the index wraps, which lets full and empty be told apart when
//   the indices are equal.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset (pointer -> 0)
//   clear - synchronous clear (pipeline flush), pointer -> 0
//   inc   - advance the pointer by one
//   ptr   - full pointer including wrap bit
//   idx   - storage index (low ADDR_WIDTH bits)
//   wrap  - wrap bit (MSB)
// -----------------------------------------------------------------------------
module rob_ptr
    import reorder_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  inc,
    output logic [ADDR_WIDTH:0]   ptr,
    output logic [ADDR_WIDTH-1:0] idx,
    output logic                  wrap
);

    logic [ADDR_WIDTH:0] ptr_q;

    // Natural binary overflow of the low bits carries into the wrap bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + 1'b1;
        end
    end

    assign ptr  = ptr_q;
    assign idx  = ptr_q[ADDR_WIDTH-1:0];
    assign wrap = ptr_q[ADDR_WIDTH];

endmodule

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//   Circular reorder-buffer storage behind the ROB issue/commit stage.
//   One entry is allocated per cycle at the tail (its ref id is write_addr),
//   functional units write results back by ref id, and the oldest entry is
//   presented for in-order commit and popped on commit_en. flush empties the
//   buffer and returns both pointers to zero.
//
// Optional feature macro: ROB_OPERAND_READ_EN
//   When defined, two combinational operand lookup ports are added
//   (rd_ref_id_1/2 -> rd_ready_1/2, rd_data_1/2) with same-cycle writeback
//   forwarding. When undefined those ports do not exist.
//
// Ports:
//   clk, rst                   - clock; synchronous active-low reset
//   flush                      - clear all entries and pointers
//   write_en / can_write       - allocate at tail / buffer not full
//   write_addr                 - ref id of the entry allocated this cycle
//   write_*                    - payload of the dispatching instruction
//   wb_en, wb_ref_id, wb_data,
//   wb_exception_type          - functional-unit writeback
//   commit_en / can_commit     - pop head / head valid and done
//   commit_*                   - head entry fields, zero when !can_commit
// -----------------------------------------------------------------------------
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif
`ifndef EXC_TYPE_NULL
`define EXC_TYPE_NULL 5'h00
`endif
`ifndef ROB_ADDR_WIDTH
`define ROB_ADDR_WIDTH 4
`endif

module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int                   ADDR_WIDTH = `ROB_ADDR_WIDTH,
    parameter logic [`EXC_TYPE_BUS] EXC_NULL   = `EXC_TYPE_NULL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic                  write_en,
    output logic                  can_write,
    output logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  write_reg_write_en,
    input  logic [4:0]            write_reg_write_addr,
    input  logic [`EXC_TYPE_BUS]  write_exception_type,
    input  logic                  write_is_delayslot,
    input  logic [31:0]           write_pc,

    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_ref_id,
    input  logic [31:0]           wb_data,
    input  logic [`EXC_TYPE_BUS]  wb_exception_type,

`ifdef ROB_OPERAND_READ_EN
    input  logic [ADDR_WIDTH-1:0] rd_ref_id_1,
    input  logic [ADDR_WIDTH-1:0] rd_ref_id_2,
    output logic                  rd_ready_1,
    output logic                  rd_ready_2,
    output logic [31:0]           rd_data_1,
    output logic [31:0]           rd_data_2,
`endif

    input  logic                  commit_en,
    output logic                  can_commit,
    output logic                  commit_reg_write_en,
    output logic [4:0]            commit_reg_write_addr,
    output logic [31:0]           commit_reg_write_data,
    output logic [`EXC_TYPE_BUS]  commit_exception_type,
    output logic                  commit_is_delayslot,
    output logic [31:0]           commit_pc
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;
    rob_entry_t       entries [DEPTH];

    logic [ADDR_WIDTH:0]   head_ptr;
    logic [ADDR_WIDTH:0]   tail_ptr;
    logic [ADDR_WIDTH-1:0] head_idx;
    logic [ADDR_WIDTH-1:0] tail_idx;
    logic                  head_wrap;
    logic                  tail_wrap;

    logic empty;
    logic full;
    logic alloc_fire;
    logic wb_fire;
    logic commit_fire;

    rob_entry_t head_entry;

    rob_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_head_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (commit_fire),
        .ptr   (head_ptr),
        .idx   (head_idx),
        .wrap  (head_wrap)
    );

    rob_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_tail_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .inc   (alloc_fire),
        .ptr   (tail_ptr),
        .idx   (tail_idx),
        .wrap  (tail_wrap)
    );

    // Same index with differing wrap bits means the tail has lapped the head.
    assign empty = (head_ptr == tail_ptr);
    assign full  = (head_idx == tail_idx) && (head_wrap != tail_wrap);

    assign can_write  = !full;
    assign write_addr = tail_idx;
    assign can_commit = !empty && valid[head_idx] && done[head_idx];

    // Pointer counters see the same flush priority, so the fire strobes
    // themselves do not need to be masked by flush.
    assign alloc_fire  = write_en && can_write;
    assign wb_fire     = wb_en && valid[wb_ref_id];
    assign commit_fire = commit_en && can_commit;

    // Writeback, then commit, then allocate. Commit only pops entries that
    // were already done, so a writeback to the popped head is harmless;
    // allocation can only target the head slot when the buffer is empty, in
    // which case nothing commits. The data field is zeroed on allocation so
    // that an entry born with an exception commits a deterministic value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
            done  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
            done  <= '0;
        end else begin
            if (wb_fire) begin
                entries[wb_ref_id].data <= wb_data;
                done[wb_ref_id]         <= 1'b1;
                if (entries[wb_ref_id].exc_type == EXC_NULL) begin
                    entries[wb_ref_id].exc_type <= wb_exception_type;
                end
            end
            if (commit_fire) begin
                valid[head_idx] <= 1'b0;
                done[head_idx]  <= 1'b0;
            end
            if (alloc_fire) begin
                valid[tail_idx]   <= 1'b1;
                done[tail_idx]    <= (write_exception_type != EXC_NULL);
                entries[tail_idx] <= '{
                    reg_write_en: write_reg_write_en,
                    reg_addr:     write_reg_write_addr,
                    data:         '0,
                    exc_type:     write_exception_type,
                    is_delayslot: write_is_delayslot,
                    pc:           write_pc
                };
            end
        end
    end

    assign head_entry = can_commit ? entries[head_idx] : '0;

    assign commit_reg_write_en   = head_entry.reg_write_en;
    assign commit_reg_write_addr = head_entry.reg_addr;
    assign commit_reg_write_data = head_entry.data;
    assign commit_exception_type = head_entry.exc_type;
    assign commit_is_delayslot   = head_entry.is_delayslot;
    assign commit_pc             = head_entry.pc;

`ifdef ROB_OPERAND_READ_EN
    // A result arriving this cycle is forwarded so the II stage does not have
    // to wait one more cycle for it to land in storage.
    always_comb begin
        rd_ready_1 = valid[rd_ref_id_1] && done[rd_ref_id_1];
        rd_data_1  = entries[rd_ref_id_1].data;
        rd_ready_2 = valid[rd_ref_id_2] && done[rd_ref_id_2];
        rd_data_2  = entries[rd_ref_id_2].data;
        if (wb_fire && (wb_ref_id == rd_ref_id_1)) begin
            rd_ready_1 = 1'b1;
            rd_data_1  = wb_data;
        end
        if (wb_fire && (wb_ref_id == rd_ref_id_2)) begin
            rd_ready_2 = 1'b1;
            rd_data_2  = wb_data;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//   Directed scenarios followed by randomized traffic for reorder_buffer.
//   The reference model tracks the buffer as unbounded allocate/commit counts
//   plus per-id records; liveness of an id is derived from its distance to
//   the oldest entry.
// -----------------------------------------------------------------------------
`ifndef EXC_TYPE_BUS
`define EXC_TYPE_BUS 4:0
`endif

module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        write_en = 1'b0;
    logic        can_write;
    logic [3:0]  write_addr;
    logic        write_reg_write_en = 1'b0;
    logic [4:0]  write_reg_write_addr = '0;
    logic [`EXC_TYPE_BUS] write_exception_type = '0;
    logic        write_is_delayslot = 1'b0;
    logic [31:0] write_pc = '0;
    logic        wb_en = 1'b0;
    logic [3:0]  wb_ref_id = '0;
    logic [31:0] wb_data = '0;
    logic [`EXC_TYPE_BUS] wb_exception_type = '0;
    logic        commit_en = 1'b0;
    logic        can_commit;
    logic        commit_reg_write_en;
    logic [4:0]  commit_reg_write_addr;
    logic [31:0] commit_reg_write_data;
    logic [`EXC_TYPE_BUS] commit_exception_type;
    logic        commit_is_delayslot;
    logic [31:0] commit_pc;
`ifdef ROB_OPERAND_READ_EN
    logic [3:0]  rd_ref_id_1 = '0;
    logic [3:0]  rd_ref_id_2 = '0;
    logic        rd_ready_1;
    logic        rd_ready_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;
`endif

    int checks = 0;
    int failures = 0;

    // Reference model state
    int          m_head;
    int          m_tail;
    logic        m_done [DEPTH];
    logic        m_rwe  [DEPTH];
    logic [4:0]  m_raddr[DEPTH];
    logic [31:0] m_data [DEPTH];
    logic [4:0]  m_exc  [DEPTH];
    logic        m_ds   [DEPTH];
    logic [31:0] m_pc   [DEPTH];

    reorder_buffer dut (
        .clk                   (clk),
        .rst                   (rst),
        .flush                 (flush),
        .write_en              (write_en),
        .can_write             (can_write),
        .write_addr            (write_addr),
        .write_reg_write_en    (write_reg_write_en),
        .write_reg_write_addr  (write_reg_write_addr),
        .write_exception_type  (write_exception_type),
        .write_is_delayslot    (write_is_delayslot),
        .write_pc              (write_pc),
        .wb_en                 (wb_en),
        .wb_ref_id             (wb_ref_id),
        .wb_data               (wb_data),
        .wb_exception_type     (wb_exception_type),
`ifdef ROB_OPERAND_READ_EN
        .rd_ref_id_1           (rd_ref_id_1),
        .rd_ref_id_2           (rd_ref_id_2),
        .rd_ready_1            (rd_ready_1),
        .rd_ready_2            (rd_ready_2),
        .rd_data_1             (rd_data_1),
        .rd_data_2             (rd_data_2),
`endif
        .commit_en             (commit_en),
        .can_commit            (can_commit),
        .commit_reg_write_en   (commit_reg_write_en),
        .commit_reg_write_addr (commit_reg_write_addr),
        .commit_reg_write_data (commit_reg_write_data),
        .commit_exception_type (commit_exception_type),
        .commit_is_delayslot   (commit_is_delayslot),
        .commit_pc             (commit_pc)
    );

    always #5 clk = ~clk;

    function automatic int occupancy();
        return m_tail - m_head;
    endfunction

    function automatic bit isLive(input int id);
        return ((id - (m_head % DEPTH) + DEPTH) % DEPTH) < occupancy();
    endfunction

    function automatic bit modelCanCommit();
        return (occupancy() > 0) && (m_done[m_head % DEPTH] == 1'b1);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        int hid;
        bit cc;
        hid = m_head % DEPTH;
        cc  = modelCanCommit();
        checkValue("can_write",  32'(can_write),  32'(occupancy() < DEPTH));
        checkValue("write_addr", 32'(write_addr), 32'(m_tail % DEPTH));
        checkValue("can_commit", 32'(can_commit), 32'(cc));
        checkValue("commit_reg_write_en",   32'(commit_reg_write_en),   cc ? 32'(m_rwe[hid])   : 32'd0);
        checkValue("commit_reg_write_addr", 32'(commit_reg_write_addr), cc ? 32'(m_raddr[hid]) : 32'd0);
        checkValue("commit_reg_write_data", commit_reg_write_data,      cc ? m_data[hid]       : 32'd0);
        checkValue("commit_exception_type", 32'(commit_exception_type), cc ? 32'(m_exc[hid])   : 32'd0);
        checkValue("commit_is_delayslot",   32'(commit_is_delayslot),   cc ? 32'(m_ds[hid])    : 32'd0);
        checkValue("commit_pc",             commit_pc,                  cc ? m_pc[hid]         : 32'd0);
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelUpdate();
        int  hid;
        int  tid;
        int  bid;
        bit  do_wb;
        bit  do_commit;
        bit  do_alloc;
        if (!rst) begin
            m_head = 0;
            m_tail = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_done[i] = 0; m_rwe[i] = 0; m_raddr[i] = 0; m_data[i] = 0;
                m_exc[i] = 0; m_ds[i] = 0; m_pc[i] = 0;
            end
        end else if (flush) begin
            m_head = 0;
            m_tail = 0;
            for (int i = 0; i < DEPTH; i++) m_done[i] = 0;
        end else begin
            hid       = m_head % DEPTH;
            tid       = m_tail % DEPTH;
            bid       = int'(wb_ref_id);
            do_wb     = wb_en && isLive(bid);
            do_commit = commit_en && modelCanCommit();
            do_alloc  = write_en && (occupancy() < DEPTH);
            if (do_wb) begin
                m_data[bid] = wb_data;
                m_done[bid] = 1;
                if (m_exc[bid] == 5'd0) m_exc[bid] = wb_exception_type;
            end
            if (do_commit) begin
                m_done[hid] = 0;
                m_head++;
            end
            if (do_alloc) begin
                m_rwe[tid]   = write_reg_write_en;
                m_raddr[tid] = write_reg_write_addr;
                m_data[tid]  = 32'd0;
                m_exc[tid]   = write_exception_type;
                m_ds[tid]    = write_is_delayslot;
                m_pc[tid]    = write_pc;
                m_done[tid]  = (write_exception_type != 5'd0);
                m_tail++;
            end
        end
    endtask

    task automatic applyStimulus(input bit w, input logic [4:0] wreg, input logic [31:0] wpc,
                                 input logic [4:0] wexc, input bit b, input int bid,
                                 input logic [31:0] bdata, input logic [4:0] bexc,
                                 input bit c, input bit f);
        write_en             = w;
        write_reg_write_en   = (wreg != 5'd0);
        write_reg_write_addr = wreg;
        write_pc             = wpc;
        write_exception_type = wexc;
        write_is_delayslot   = wpc[2];
        wb_en                = b;
        wb_ref_id            = 4'(bid);
        wb_data              = bdata;
        wb_exception_type    = bexc;
        commit_en            = c;
        flush                = f;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check at the falling edge, then let the DUT and the model take the edge.
    task automatic cycle();
        @(negedge clk);
        checkOutput();
        modelUpdate();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] rexc;
        logic [4:0] rbexc;

        // Reset
        idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        modelUpdate();
        rst = 1'b1;
        checkValue("reset_can_write",  32'(can_write),  32'd1);
        checkValue("reset_write_addr", 32'(write_addr), 32'd0);
        checkValue("reset_can_commit", 32'(can_commit), 32'd0);
        checkValue("reset_commit_pc",  commit_pc,       32'd0);
        cycle();

        // Single allocate / writeback / commit
        applyStimulus(1'b1, 5'd5, 32'h100, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 0, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0);
        checkValue("single_cc_before_wb", 32'(can_commit), 32'd0);
        cycle();
        checkValue("single_cc_after_wb", 32'(can_commit),            32'd1);
        checkValue("single_reg_addr",    32'(commit_reg_write_addr), 32'd5);
        checkValue("single_data",        commit_reg_write_data,      32'hDEADBEEF);
        checkValue("single_pc",          commit_pc,                  32'h100);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b1, 1'b0);
        cycle();
        idle();
        checkValue("single_empty_cc", 32'(can_commit), 32'd0);
        checkValue("single_empty_cw", 32'(can_write),  32'd1);
        cycle();

        // Fill to full, drop the 17th allocate, free one slot
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 32'h1000 + 32'(i * 4), 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
            cycle();
        end
        checkValue("full_can_write",  32'(can_write),  32'd0);
        checkValue("full_write_addr", 32'(write_addr), 32'd0);
        applyStimulus(1'b1, 5'd31, 32'hBAD0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        checkValue("drop_write_addr", 32'(write_addr), 32'd0);
        checkValue("drop_can_write",  32'(can_write),  32'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 0, 32'h11, 5'd0, 1'b0, 1'b0);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b1, 1'b0);
        cycle();
        idle();
        checkValue("freed_can_write", 32'(can_write), 32'd1);
        cycle();

        // Out-of-order writeback, in-order commit
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'(i + 8), 32'h200 + 32'(i * 4), 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
            cycle();
        end
        for (int i = 2; i >= 0; i--) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, i, 32'hA0 + 32'(i), 5'd0, 1'b0, 1'b0);
            cycle();
        end
        checkValue("ooo_pc0", commit_pc, 32'h200);
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b1, 1'b0);
        cycle();
        checkValue("ooo_pc1", commit_pc, 32'h204);
        cycle();
        checkValue("ooo_pc2", commit_pc, 32'h208);
        cycle();
        checkValue("ooo_done_cc", 32'(can_commit), 32'd0);
        idle();

        // Exception at dispatch: done at once, earliest exception wins
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle();
        applyStimulus(1'b1, 5'd3, 32'h300, EXC_IF, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b0);
        cycle();
        idle();
        checkValue("exc_cc",   32'(can_commit),            32'd1);
        checkValue("exc_type", 32'(commit_exception_type), 32'(EXC_IF));
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b1, 0, 32'h55, EXC_OV, 1'b0, 1'b0);
        cycle();
        checkValue("exc_kept", 32'(commit_exception_type), 32'(EXC_IF));
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b1, 1'b0);
        cycle();

        // Steady state across the wrap point, then flush mid-stream
        applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 0, 32'd0, 5'd0, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(i + 1), 32'h400 + 32'(i * 4), 5'd0, i > 0, i - 1,
                          32'h5000 + 32'(i), 5'd0, 1'b0, 1'b0);
            cycle();
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 5'(i + 11), 32'h800 + 32'(i * 4), 5'd0, 1'b1, (m_tail - 1) % DEPTH,
                          32'h6000 + 32'(i), 5'd0, 1'b1, 1'b0);
            cycle();
        end
        checkValue("wrap_write_addr", 32'(write_addr), 32'd14);
        checkValue("wrap_can_commit", 32'(can_commit), 32'd1);
        applyStimulus(1'b1, 5'd7, 32'h900, 5'd0, 1'b1, 3, 32'h77, 5'd0, 1'b1, 1'b1);
        cycle();
        idle();
        checkValue("flush_can_commit", 32'(can_commit), 32'd0);
        checkValue("flush_write_addr", 32'(write_addr), 32'd0);
        checkValue("flush_can_write",  32'(can_write),  32'd1);
        cycle();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rexc  = ($urandom % 8 == 0) ? 5'(1 + $urandom % 4) : 5'd0;
            rbexc = ($urandom % 6 == 0) ? 5'(1 + $urandom % 4) : 5'd0;
            applyStimulus(($urandom % 3) != 0, 5'($urandom), $urandom, rexc,
                          1'($urandom), int'($urandom % 16), $urandom, rbexc,
                          1'($urandom), ($urandom % 97) == 0);
            rst = (($urandom % 500) != 0);
            cycle();
        end
        rst = 1'b1;
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
